bus_write_responder: RTL
========================

// Module: bus_write_responder
// PURPOSE
//  Target (responder) side of the bus_if write channels: AW, W and B.
//  - Accepts write address and write data independently, in either order.
//  - Commits the write into a byte-enabled register bank.
//  - Returns a B response: OKAY on a decoded write, SLVERR otherwise.
//  - Sits behind bus_if as the memory-mapped target for write-master benches and
//    exposes a read-only peek port so checkers can observe register contents.
// PARAMETERS
//  ADDR_W    32  address width (bits)
//  DATA_W    32  data width (bits); must be 32 or 64; STRB_W = DATA_W/8
//  NUM_REGS  16  number of DATA_W registers, at byte base 0, stride DATA_W/8
// PORTS
//  clk         in   1        clock; all logic on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  awaddr      in   ADDR_W   write byte address
//  awvalid     in   1        write address valid
//  awready     out  1        write address ready
//  wdata       in   DATA_W   write data
//  wstrb       in   STRB_W   byte enables; bit i covers wdata[8i+7:8i]
//  wvalid      in   1        write data valid
//  wready      out  1        write data ready
//  bresp       out  2        write response: 0 = OKAY, 2 = SLVERR
//  bvalid      out  1        write response valid
//  bready      in   1        write response ready
//  rd_idx      in   $clog2(NUM_REGS)  peek register index
//  rd_data     out  DATA_W   combinational regs[rd_idx]
//  wr_evt      out  1        one-cycle pulse on every successful register write
//  wr_evt_idx  out  $clog2(NUM_REGS)  index written; valid while wr_evt = 1
// BEHAVIOUR
//  Reset (async assert, sync deassert use)
//  - Registers: aw_full = 0, w_full = 0, bvalid = 0, bresp = 0, wr_evt = 0,
//    wr_evt_idx = 0, all regs = 0.
//  - awready and wready read 1 once reset is released.
//  - A reset mid-transaction drops held AW/W and any pending B. No write commits.
//  Capture
//  - awready = !aw_full. On awvalid & awready, latch awaddr and set aw_full.
//  - wready = !w_full. On wvalid & wready, latch wdata/wstrb and set w_full.
//  - AW and W can be captured on the same edge or in either order.
//    There is no cap on the skew between them.
//  Commit (one edge)
//  - Condition: aw_full & w_full & (!bvalid | bready).
//  - Clears aw_full and w_full.
//  - Sets bvalid = 1 and loads bresp.
//  - If OKAY: regs[idx] byte lanes with wstrb = 1 take wdata; other lanes keep
//    their value. wr_evt = 1 and wr_evt_idx = idx for exactly one cycle.
//  - Address decode: idx = awaddr >> log2(STRB_W).
//    OKAY requires the low log2(STRB_W) address bits = 0 and idx < NUM_REGS;
//    otherwise SLVERR, with no register change and no wr_evt.
//  - wstrb = 0 to a valid address gives OKAY, no data change, and wr_evt still pulses.
//  Response
//  - Latency: bvalid rises on the edge after the later of the two handshakes.
//    With simultaneous AW/W handshakes on edge N, bvalid = 1 from edge N+1.
//  - bvalid and bresp hold stable until bvalid & bready. bvalid then clears,
//    unless a new commit on that same edge re-asserts it with the new bresp.
//  - While B is stalled (bvalid & !bready), the next AW and W can still each be
//    captured once. Further handshakes stall via awready/wready = 0.
//    Responses stay in order.
//  Peek port
//  - rd_data is combinational from regs.
//  - rd_idx >= NUM_REGS returns 0.
//  - A same-cycle commit is visible on the following cycle.
// TESTING
//  1 Reset release: awready = wready = 1, bvalid = 0, rd_data = 0 for every rd_idx.
//  2 AW 0x4 and W 0x12345678/strb 0xF in the same cycle, bready = 1 ->
//    bvalid next cycle, bresp = 0, regs[1] = 0x12345678, wr_evt pulse with idx 1.
//  3 W first (0xAAAABBBB, strb 0x3), AW 0x8 three cycles later, regs[2] = 0xFFFFFFFF
//    beforehand -> regs[2] = 0xFFFFBBBB, bresp = 0, one wr_evt.
//  4 AW 0x40 (out of range), then AW 0x6 (misaligned) ->
//    each returns bresp = 2, no register change, no wr_evt.
//  5 bready = 0 for 5 cycles with 3 back-to-back writes queued ->
//    second AW/W accepted, then awready = wready = 0.
//    bvalid/bresp stable throughout; all 3 responses arrive in order once bready = 1.
//  6 rst_n pulsed low with AW held and W not yet sent ->
//    no write, bvalid = 0, regs cleared, fresh transaction afterwards completes OKAY.

Source files
------------

// File: rtl/bus_write_responder.sv
// bus_write_responder: write-channel target (AW, W, B) in front of a
// byte-enabled register bank, with a combinational peek port and a
// one-cycle write event pulse for checkers.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid and ready are both 1. A source holds valid and its payload
// stable until that edge. awready/wready depend only on the local holding
// flags, and bvalid/bresp hold until bready is seen, so no ready waits on a
// valid in the same cycle.
module bus_write_responder #(
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int STRB_W   = DATA_W / 8,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_evt,
  output logic [IDX_W-1:0]  wr_evt_idx
);

  localparam int         LSB_W       = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One-deep holding stages for the address and data channels.
  logic              aw_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic              w_full;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              commit;
  logic              addr_ok;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;

  assign awready = !aw_full;
  assign wready  = !w_full;

  // A commit needs both halves and a free (or freeing) response slot.
  assign commit = aw_full && w_full && (!bvalid || bready);

  // Word index from the byte address; must be aligned and inside the bank.
  assign word_addr = aw_addr_q >> LSB_W;
  assign addr_ok   = (aw_addr_q[LSB_W-1:0] == '0) && (word_addr < ADDR_W'(NUM_REGS));
  assign idx       = word_addr[IDX_W-1:0];

  // Address holding stage: fill on handshake, empty on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
    end else if (awvalid && !aw_full) begin
      aw_full   <= 1'b1;
      aw_addr_q <= awaddr;
    end else if (commit) begin
      aw_full   <= 1'b0;
    end
  end

  // Data holding stage: fill on handshake, empty on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (wvalid && !w_full) begin
      w_full   <= 1'b1;
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end else if (commit) begin
      w_full   <= 1'b0;
    end
  end

  // Response slot: a commit loads it (possibly on the edge the old one
  // drains); otherwise it clears when the master accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= addr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
  end

  // Write event pulse: high for the single cycle after a successful commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_evt     <= 1'b0;
      wr_evt_idx <= '0;
    end else begin
      wr_evt <= commit && addr_ok;
      if (commit && addr_ok) begin
        wr_evt_idx <= idx;
      end
    end
  end

  // Register bank: byte lanes with a set strobe take the held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && addr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) begin
          regs[idx][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  // Peek port; indices past the bank read as zero.
  generate
    if ((1 << IDX_W) == NUM_REGS) begin : g_peek_full
      assign rd_data = regs[rd_idx];
    end else begin : g_peek_partial
      assign rd_data = (32'(rd_idx) < NUM_REGS) ? regs[rd_idx] : '0;
    end
  endgenerate

endmodule
